multicycle_ctrl: RTL and testbench



---
 rtl/mctrl_pkg.sv | 57 +++++
 rtl/mctrl_decode.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared types for the multicycle controller: opcodes, FSM states, ALU
// operation codes and the bundle of decoded per-instruction controls.
package mctrl_pkg;

   typedef enum logic [3:0] {
      OP_JMP  = 4'h0,
      OP_JEQ  = 4'h1,
      OP_JNE  = 4'h2,
      OP_JLT  = 4'h3,
      OP_JGE  = 4'h4,
      OP_ADD  = 4'h5,
      OP_XOR  = 4'h6,
      OP_STR  = 4'h7,
      OP_LD   = 4'h8,
      OP_HALT = 4'h9,
      OP_MOVF = 4'hA,
      OP_SUB  = 4'hB,
      OP_CMP  = 4'hC,
      OP_LSL  = 4'hD,
      OP_MOVI = 4'hE,
      OP_RSL  = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_ERR
   } state_e;

   localparam int ALUOP_W = 3;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_LSL = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_RSL = 3'b101;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUOP_W-1:0] ALU_CMP = 3'b111;

   // wrreg/halt are routing qualifiers used by the FSM, not ports by themselves
   typedef struct packed {
      logic               uncdjmp;
      logic               jtype;
      logic               itype;
      logic               rdmem;
      logic               wrmem;
      logic               movf;
      logic               wrreg;
      logic               halt;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode-to-control decoder; the controller registers its
// output once per instruction.
module mctrl_decode
   import mctrl_pkg::*;
(
   input  logic [3:0] op,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode_e'(op))
         OP_JMP: begin
            ctrl.uncdjmp = 1'b1;
            ctrl.jtype   = 1'b1;
         end
         OP_JEQ, OP_JNE, OP_JLT, OP_JGE: ctrl.jtype = 1'b1;
         OP_ADD: begin
            ctrl.aluop = ALU_ADD;
            ctrl.wrreg = 1'b1;
         end
         OP_XOR: begin
            ctrl.aluop = ALU_XOR;
            ctrl.wrreg = 1'b1;
         end
         OP_STR:  ctrl.wrmem = 1'b1;
         OP_LD: begin
            ctrl.rdmem = 1'b1;
            ctrl.wrreg = 1'b1;
         end
         OP_HALT: ctrl.halt = 1'b1;
         OP_MOVF: begin
            ctrl.movf  = 1'b1;
            ctrl.wrreg = 1'b1;
         end
         OP_SUB: begin
            ctrl.aluop = ALU_SUB;
            ctrl.wrreg = 1'b1;
         end
         // compare only sets flags, so no register write-back
         OP_CMP:  ctrl.aluop = ALU_CMP;
         OP_LSL: begin
            ctrl.itype = 1'b1;
            ctrl.aluop = ALU_LSL;
            ctrl.wrreg = 1'b1;
         end
         OP_MOVI: begin
            ctrl.itype = 1'b1;
            ctrl.wrreg = 1'b1;
         end
         OP_RSL: begin
            ctrl.itype = 1'b1;
            ctrl.aluop = ALU_RSL;
            ctrl.wrreg = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with memory-wait timeout.
// Define MCTRL_PERF_CNT_EN to add the CycleCnt/InstrCnt performance counters.
module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int OPWIDTH    = 4,
   parameter int ALUOPWIDTH = 3,
   parameter int MAXWAIT    = 15
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Start,
   input  logic [OPWIDTH-1:0]    Instr,
   input  logic                  MemAck,
   output logic                  IRLoad,
   output logic                  PCEn,
   output logic                  UncdJmp,
   output logic                  JType,
   output logic                  IType,
   output logic                  RdMem,
   output logic                  WrMem,
   output logic                  WrReg,
   output logic                  Movf,
   output logic [ALUOPWIDTH-1:0] ALUOp,
   output logic                  MemReq,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err
`ifdef MCTRL_PERF_CNT_EN
   ,
   output logic [31:0]           CycleCnt,
   output logic [31:0]           InstrCnt
`endif
);

   localparam int CW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

   state_e        state, state_nxt;
   ctrl_t         dec, ctrl_q;
   logic [CW-1:0] wait_cnt;
   logic          timeout;

   // only the low nibble carries the opcode; wider instruction fields are ignored
   mctrl_decode u_decode (
      .op   (Instr[3:0]),
      .ctrl (dec)
   );

   assign timeout = (wait_cnt == CW'(MAXWAIT));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= S_IDLE;
         ctrl_q   <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE)
            ctrl_q <= dec;
         if (state == S_MEM && !MemAck)
            wait_cnt <= wait_cnt + CW'(1);
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      IRLoad    = 1'b0;
      PCEn      = 1'b0;
      WrMem     = 1'b0;
      WrReg     = 1'b0;
      MemReq    = 1'b0;
      Busy      = 1'b1;
      Done      = 1'b0;
      Err       = 1'b0;
      case (state)
         S_IDLE: begin
            Busy = 1'b0;
            if (Start)
               state_nxt = S_FETCH;
         end
         S_FETCH: begin
            IRLoad    = 1'b1;
            state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC: begin
            if (ctrl_q.jtype) begin
               PCEn      = 1'b1;
               state_nxt = S_FETCH;
            end else if (ctrl_q.rdmem || ctrl_q.wrmem)
               state_nxt = S_MEM;
            else if (ctrl_q.halt)
               state_nxt = S_HALT;
            else
               state_nxt = S_WB;
         end
         // an ack on the final allowed cycle wins over the timeout
         S_MEM: begin
            MemReq = 1'b1;
            WrMem  = ctrl_q.wrmem;
            if (MemAck) begin
               if (ctrl_q.rdmem)
                  state_nxt = S_WB;
               else begin
                  PCEn      = 1'b1;
                  state_nxt = S_FETCH;
               end
            end else if (timeout)
               state_nxt = S_ERR;
         end
         S_WB: begin
            PCEn      = 1'b1;
            WrReg     = ctrl_q.wrreg;
            state_nxt = S_FETCH;
         end
         S_HALT: begin
            Busy = 1'b0;
            Done = 1'b1;
         end
         S_ERR: begin
            Busy = 1'b0;
            Err  = 1'b1;
         end
         default: begin
            Busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign UncdJmp = ctrl_q.uncdjmp;
   assign JType   = ctrl_q.jtype;
   assign IType   = ctrl_q.itype;
   assign RdMem   = ctrl_q.rdmem;
   assign Movf    = ctrl_q.movf;
   assign ALUOp   = ALUOPWIDTH'(ctrl_q.aluop);

`ifdef MCTRL_PERF_CNT_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         CycleCnt <= '0;
         InstrCnt <= '0;
      end else begin
         if (Busy)
            CycleCnt <= CycleCnt + 32'd1;
         if (state == S_EXEC)
            InstrCnt <= InstrCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level schedule model
// predicts every output on every cycle, including timeouts and resets.
module tb_multicycle_ctrl;

   localparam int MAXWAIT = 15;

   logic       Clk     = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Start   = 1'b0;
   logic [3:0] Instr   = '0;
   logic       MemAck  = 1'b0;
   logic       IRLoad, PCEn, UncdJmp, JType, IType, RdMem, WrMem, WrReg, Movf;
   logic [2:0] ALUOp;
   logic       MemReq, Busy, Done, Err;
`ifdef MCTRL_PERF_CNT_EN
   logic [31:0] CycleCnt, InstrCnt;
   logic [31:0] m_cyc = '0;
   logic [31:0] m_ins = '0;
`endif

   int n_vec = 0;
   int n_err = 0;

   // controls latched by the most recent decode, as the model sees them
   logic       pu = 1'b0, pj = 1'b0, pi = 1'b0, pr = 1'b0, pm = 1'b0;
   logic [2:0] pa = '0;

   multicycle_ctrl #(.OPWIDTH(4), .ALUOPWIDTH(3), .MAXWAIT(MAXWAIT)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .Start   (Start),
      .Instr   (Instr),
      .MemAck  (MemAck),
      .IRLoad  (IRLoad),
      .PCEn    (PCEn),
      .UncdJmp (UncdJmp),
      .JType   (JType),
      .IType   (IType),
      .RdMem   (RdMem),
      .WrMem   (WrMem),
      .WrReg   (WrReg),
      .Movf    (Movf),
      .ALUOp   (ALUOp),
      .MemReq  (MemReq),
      .Busy    (Busy),
      .Done    (Done),
      .Err     (Err)
`ifdef MCTRL_PERF_CNT_EN
      ,
      .CycleCnt(CycleCnt),
      .InstrCnt(InstrCnt)
`endif
   );

   always #5 Clk = ~Clk;

   function automatic logic [2:0] alu_of(input logic [3:0] op);
      case (op)
         4'd5:    return 3'b000;
         4'd6:    return 3'b011;
         4'd11:   return 3'b110;
         4'd12:   return 3'b111;
         4'd13:   return 3'b001;
         4'd15:   return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [15:0] obs();
      return {IRLoad, PCEn, UncdJmp, JType, IType, RdMem, WrMem, WrReg, Movf,
              ALUOp, MemReq, Busy, Done, Err};
   endfunction

   function automatic logic [15:0] exp_v(input logic irl, pce, wm, wr, mr, bsy, dn, er);
      return {irl, pce, pu, pj, pi, pr, wm, wr, pm, pa, mr, bsy, dn, er};
   endfunction

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check_vec(tag, 32'(obs()), 32'd0);
`ifdef MCTRL_PERF_CNT_EN
      check_vec({tag, "_cyc"}, CycleCnt, 32'd0);
      check_vec({tag, "_ins"}, InstrCnt, 32'd0);
`endif
   endtask

   // inputs already driven at this negedge; check, then advance one cycle
   task automatic cycle_chk(input string tag, input logic [15:0] want);
      #1;
      check_vec(tag, 32'(obs()), 32'(want));
`ifdef MCTRL_PERF_CNT_EN
      check_vec({tag, "_cyc"}, CycleCnt, m_cyc);
      check_vec({tag, "_ins"}, InstrCnt, m_ins);
      if (want[2]) m_cyc = m_cyc + 32'd1;
      if (tag == "exec") m_ins = m_ins + 32'd1;
`endif
      @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      Start   = 1'($urandom);
      MemAck  = 1'($urandom);
      @(negedge Clk);
      #1;
      check_zero("reset");
      pu = 1'b0; pj = 1'b0; pi = 1'b0; pr = 1'b0; pm = 1'b0; pa = '0;
`ifdef MCTRL_PERF_CNT_EN
      m_cyc = '0;
      m_ins = '0;
`endif
      @(negedge Clk);
      Reset_n = 1'b1;
      Start   = 1'b0;
      MemAck  = 1'b0;
   endtask

   task automatic run_instr(input logic [3:0] op, input int nwait, input int rst_at,
                            output bit term);
      logic jmp, st, ld, hl, wr, ack;
      jmp  = (op <= 4'd4);
      st   = (op == 4'd7);
      ld   = (op == 4'd8);
      hl   = (op == 4'd9);
      wr   = !(jmp || st || hl || op == 4'd12);
      term = 1'b0;

      Start = 1'($urandom); Instr = 4'($urandom); MemAck = 1'($urandom);
      cycle_chk("fetch", exp_v(1, 0, 0, 0, 0, 1, 0, 0));
      Start = 1'($urandom); Instr = op; MemAck = 1'($urandom);
      cycle_chk("decode", exp_v(0, 0, 0, 0, 0, 1, 0, 0));
      pu = (op == 4'd0); pj = jmp; pi = (op >= 4'd13); pr = ld; pm = (op == 4'd10);
      pa = alu_of(op);
      Start = 1'($urandom); Instr = 4'($urandom); MemAck = 1'($urandom);
      cycle_chk("exec", exp_v(0, jmp, 0, 0, 0, 1, 0, 0));
      if (jmp) return;

      if (hl) begin
         for (int i = 0; i < 3; i++) begin
            Start = 1'($urandom); MemAck = 1'($urandom);
            cycle_chk("halt", exp_v(0, 0, 0, 0, 0, 0, 1, 0));
         end
         term = 1'b1;
         return;
      end

      if (st || ld) begin
         for (int k = 0; k <= MAXWAIT; k++) begin
            ack    = (k == nwait);
            MemAck = ack; Start = 1'($urandom); Instr = 4'($urandom);
            cycle_chk("mem", exp_v(0, st && ack, st, 0, 1, 1, 0, 0));
            if (ack) break;
            if (k == MAXWAIT) begin
               for (int i = 0; i < 3; i++) begin
                  Start = 1'($urandom); MemAck = 1'($urandom);
                  cycle_chk("err", exp_v(0, 0, 0, 0, 0, 0, 0, 1));
               end
               term = 1'b1;
               return;
            end
            if (k == rst_at) begin
               Reset_n = 1'b0;
               #1;
               check_zero("rst_mem");
               term = 1'b1;
               return;
            end
         end
         MemAck = 1'b0;
         if (st) return;
      end

      Start = 1'($urandom); MemAck = 1'($urandom); Instr = 4'($urandom);
      cycle_chk("wb", exp_v(0, 1, 0, wr, 0, 1, 0, 0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish by %0t", $time);
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      bit term;
      int op, nwait, rst_at;
      for (int p = 0; p < 40; p++) begin
         do_reset();
         repeat ($urandom_range(0, 2)) begin
            Start = 1'b0; MemAck = 1'($urandom);
            cycle_chk("idle", 16'd0);
         end
         Start = 1'b1;
         cycle_chk("idle_go", 16'd0);
         term = 1'b0;
         for (int n = 0; n < 10 && !term; n++) begin
            op     = 0;
            nwait  = 0;
            rst_at = -1;
            if (p == 0) begin
               case (n)
                  0:       op = 5;
                  1:       begin op = 8; nwait = 3; end
                  2:       op = 12;
                  3:       op = 0;
                  default: begin op = 7; nwait = MAXWAIT + 1; end
               endcase
            end else if (p == 1) begin
               op = (n < 3) ? 5 : 9;
            end else if (p == 2) begin
               op     = (n == 0) ? 8 : 5;
               nwait  = MAXWAIT + 1;
               rst_at = 2;
            end else if (p == 3) begin
               op    = (n == 0) ? 8 : 7;
               nwait = MAXWAIT;
            end else begin
               op = int'($urandom_range(0, 15));
               case ($urandom_range(0, 9))
                  0, 1, 2, 3, 4, 5: nwait = int'($urandom_range(0, 4));
                  6, 7:             nwait = MAXWAIT;
                  default:          nwait = MAXWAIT + 1;
               endcase
               if ($urandom_range(0, 7) == 0)
                  rst_at = int'($urandom_range(0, 3));
            end
            run_instr(4'(op), nwait, rst_at, term);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
